// File: rtl/pulse_histogrammer_pkg.sv
// Shared definitions for the pulse histogrammer: sizes, counter type and
// the saturating increment used by every histogram counter.
package hist_pkg;

  localparam int NCHAN = 8;
  localparam int NBINS = 64;
  localparam int CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/pulse_histogrammer_ipi_binner.sv
// Inter-pulse-interval tracker: counts cycles between IPI events and
// registers the histogram bin of each interval (first stage of the IPI pipe).
module ipi_binner #(
  parameter int NBINS     = 64,
  parameter int IVL_W     = 16,
  parameter int BIN_SHIFT = 2
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     ev,
  output logic [$clog2(NBINS)-1:0] bin_idx,
  output logic                     bin_vld
);
  import hist_pkg::*;

  localparam int BW = $clog2(NBINS);

  logic [IVL_W-1:0] ivl_q, ivl_d;
  logic [IVL_W-1:0] ivl_shr;
  logic             armed_q, armed_d;
  logic [BW-1:0]    bin_p1_q, bin_p1_d;
  logic             vld_p1_q, vld_p1_d;

  // Interval counter, armed flag and bin selection for the stage-1 register.
  always_comb begin
    ivl_d    = ivl_q;
    armed_d  = armed_q;
    vld_p1_d = 1'b0;
    ivl_shr  = ivl_q >> BIN_SHIFT;
    if (ivl_shr > IVL_W'(NBINS - 1)) begin
      bin_p1_d = BW'(NBINS - 1);
    end else begin
      bin_p1_d = ivl_shr[BW-1:0];
    end
    if (clr) begin
      ivl_d   = '0;
      armed_d = 1'b0;
    end else if (ev) begin
      // The very first event after a clear only starts the interval.
      ivl_d    = IVL_W'(1);
      armed_d  = 1'b1;
      vld_p1_d = armed_q;
    end else if (ivl_q != '1) begin
      ivl_d = ivl_q + IVL_W'(1);
    end
  end

  // Stage 1: interval state plus the registered bin and its valid bit.
  always_ff @(posedge clk) begin
    ivl_q    <= ivl_d;
    armed_q  <= armed_d;
    vld_p1_q <= vld_p1_d;
    bin_p1_q <= bin_p1_d;
  end

  assign bin_idx = bin_p1_q;
  assign bin_vld = vld_p1_q;

endmodule

// File: rtl/pulse_histogrammer.sv
// Per-channel rising-edge totals and inter-pulse-interval histogram,
// cleared by reset or by the processor's resethist request.
module pulse_histogrammer #(
  parameter int NCHAN     = 8,
  parameter int NBINS     = 64,
  parameter int CNT_W     = 32,
  parameter int IVL_W     = 16,
  parameter int BIN_SHIFT = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NCHAN-1:0]                  hit_in,
  input  logic [NCHAN-1:0]                  ipi_mask,
  input  logic                              resethist,
  output logic [NCHAN-1:0][CNT_W-1:0]       h,
  output logic [NBINS-1:0][CNT_W-1:0]       ipihist
);
  import hist_pkg::*;

  localparam int BW = $clog2(NBINS);

  logic [NCHAN-1:0] prev_q, prev_d;
  logic [NCHAN-1:0] rise;
  logic             clr;
  logic             ev;
  cnt_t [NCHAN-1:0] h_q, h_d;
  cnt_t [NBINS-1:0] ipihist_q, ipihist_d;
  logic [BW-1:0]    bin_idx;
  logic             bin_vld;

  // Edge detect and clear qualification; prev keeps tracking through resethist.
  always_comb begin
    clr    = reset | resethist;
    rise   = hit_in & ~prev_q;
    prev_d = reset ? '0 : hit_in;
    ev     = (|(rise & ipi_mask)) & ~clr;
  end

  // Channel totals: every rising channel bumps its own saturating counter.
  always_comb begin
    h_d = h_q;
    if (clr) begin
      h_d = '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (rise[i]) h_d[i] = sat_inc(h_q[i]);
      end
    end
  end

  // Stage 2: bump the bin registered by the binner one cycle earlier.
  always_comb begin
    ipihist_d = ipihist_q;
    if (clr) begin
      ipihist_d = '0;
    end else if (bin_vld) begin
      ipihist_d[bin_idx] = sat_inc(ipihist_q[bin_idx]);
    end
  end

  // State registers for edge history and both histogram arrays.
  always_ff @(posedge clk) begin
    prev_q    <= prev_d;
    h_q       <= h_d;
    ipihist_q <= ipihist_d;
  end

  ipi_binner #(
    .NBINS     (NBINS),
    .IVL_W     (IVL_W),
    .BIN_SHIFT (BIN_SHIFT)
  ) u_binner (
    .clk     (clk),
    .clr     (clr),
    .ev      (ev),
    .bin_idx (bin_idx),
    .bin_vld (bin_vld)
  );

  assign h       = h_q;
  assign ipihist = ipihist_q;

endmodule
